// File: rtl/cr16_pkg.sv
// Shared widths, checksum index and dump FSM encoding for the CR16 register dump.
// The CSUM state exists only when CR16_REG_DUMP_CHECKSUM_EN is defined.
package cr16_pkg;

  localparam int WORD_WIDTH  = 16;
  localparam int REG_COUNT   = 16;
  localparam int INDEX_WIDTH = 4;

  localparam logic [INDEX_WIDTH-1:0] CSUM_INDEX = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
`ifdef CR16_REG_DUMP_CHECKSUM_EN
    ST_CSUM   = 2'd2,
`endif
    ST_FINISH = 2'd3
  } dump_state_t;

endpackage

// File: rtl/cr16_priority_enc.sv
// Combinational priority encoder: index of the lowest set bit plus an any-set flag.
module cr16_priority_enc #(
  parameter int WIDTH       = 16,
  parameter int INDEX_WIDTH = 4
) (
  input  logic [WIDTH-1:0]       vec,
  output logic [INDEX_WIDTH-1:0] index,
  output logic                   any
);

  // Scanning from the top down lets the lowest set bit win the last assignment.
  always_comb begin
    index = '0;
    any   = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) begin
        index = INDEX_WIDTH'(i);
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cr16_reg_dump.sv
// Streams the masked register-file entries as valid/ready beats, lowest index first.
// Defining CR16_REG_DUMP_CHECKSUM_EN appends an XOR checksum beat at index 4'hF.
module cr16_reg_dump #(
  parameter int WORD_WIDTH = cr16_pkg::WORD_WIDTH,
  parameter int REG_COUNT  = cr16_pkg::REG_COUNT
) (
  input  logic                             I_CLK,
  input  logic                             I_RESET,
  input  logic [WORD_WIDTH-1:0]            I_REG_DATA [REG_COUNT],
  input  logic                             I_START,
  input  logic [REG_COUNT-1:0]             I_MASK,
  input  logic                             I_READY,
  output logic [WORD_WIDTH-1:0]            O_DATA,
  output logic [cr16_pkg::INDEX_WIDTH-1:0] O_INDEX,
  output logic                             O_VALID,
  output logic                             O_LAST,
  output logic                             O_BUSY,
  output logic                             O_DONE
);

  import cr16_pkg::*;

  dump_state_t              state, state_d;
  logic [REG_COUNT-1:0]     pending, pending_d;
  logic [WORD_WIDTH-1:0]    data_q, data_d;
  logic [INDEX_WIDTH-1:0]   index_q, index_d;
  logic                     valid_q, valid_d;
  logic                     last_q, last_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
`ifdef CR16_REG_DUMP_CHECKSUM_EN
  logic [WORD_WIDTH-1:0]    csum_q, csum_d;
`endif

  logic [REG_COUNT-1:0]     enc_vec;
  logic [REG_COUNT-1:0]     rest;
  logic [INDEX_WIDTH-1:0]   enc_index;
  logic                     enc_any;
  logic                     handshake;
  logic                     final_beat;

  // In IDLE the fresh mask feeds the encoder so the first beat loads on the start edge.
  assign enc_vec   = (state == ST_IDLE) ? I_MASK : pending;
  assign rest      = enc_vec & (enc_vec - REG_COUNT'(1));
  assign handshake = valid_q & I_READY;
`ifdef CR16_REG_DUMP_CHECKSUM_EN
  assign final_beat = 1'b0;
`else
  assign final_beat = ~|rest;
`endif

  cr16_priority_enc #(
    .WIDTH       (REG_COUNT),
    .INDEX_WIDTH (INDEX_WIDTH)
  ) u_enc (
    .vec   (enc_vec),
    .index (enc_index),
    .any   (enc_any)
  );

  always_comb begin
    // NOTE: every signal gets its default first; a path that skipped one would infer a latch.
    state_d   = state;
    pending_d = pending;
    data_d    = data_q;
    index_d   = index_q;
    valid_d   = valid_q;
    last_d    = last_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
`ifdef CR16_REG_DUMP_CHECKSUM_EN
    csum_d    = csum_q;
`endif

    case (state)
      ST_IDLE: begin
        if (I_START) begin
          busy_d = 1'b1;
`ifdef CR16_REG_DUMP_CHECKSUM_EN
          csum_d = '0;
`endif
          if (enc_any) begin
            state_d   = ST_STREAM;
            pending_d = rest;
            data_d    = I_REG_DATA[enc_index];
            index_d   = enc_index;
            valid_d   = 1'b1;
            last_d    = final_beat;
          end else begin
`ifdef CR16_REG_DUMP_CHECKSUM_EN
            state_d = ST_CSUM;
            data_d  = '0;
            index_d = CSUM_INDEX;
            valid_d = 1'b1;
            last_d  = 1'b1;
`else
            state_d = ST_FINISH;
`endif
          end
        end
      end

      ST_STREAM: begin
        if (handshake) begin
`ifdef CR16_REG_DUMP_CHECKSUM_EN
          csum_d = csum_q ^ data_q;
`endif
          // Next set index replaces the accepted beat on the same edge: no bubble.
          if (enc_any) begin
            pending_d = rest;
            data_d    = I_REG_DATA[enc_index];
            index_d   = enc_index;
            valid_d   = 1'b1;
            last_d    = final_beat;
          end else begin
`ifdef CR16_REG_DUMP_CHECKSUM_EN
            state_d = ST_CSUM;
            data_d  = csum_q ^ data_q;
            index_d = CSUM_INDEX;
            valid_d = 1'b1;
            last_d  = 1'b1;
`else
            state_d = ST_FINISH;
            valid_d = 1'b0;
            last_d  = 1'b0;
`endif
          end
        end
      end

`ifdef CR16_REG_DUMP_CHECKSUM_EN
      ST_CSUM: begin
        if (handshake) begin
          state_d = ST_FINISH;
          valid_d = 1'b0;
          last_d  = 1'b0;
        end
      end
`endif

      ST_FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge I_CLK) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    if (I_RESET) begin
      state   <= ST_IDLE;
      pending <= '0;
      data_q  <= '0;
      index_q <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef CR16_REG_DUMP_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state   <= state_d;
      pending <= pending_d;
      data_q  <= data_d;
      index_q <= index_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef CR16_REG_DUMP_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign O_DATA  = data_q;
  assign O_INDEX = index_q;
  assign O_VALID = valid_q;
  assign O_LAST  = last_q;
  assign O_BUSY  = busy_q;
  assign O_DONE  = done_q;

endmodule
